// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone RAM responder: FSM encoding, default
// base address and an address-window helper.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [31:0] WB_BASE_ADDR = 32'h3800_0000;
    localparam int          CNT_W        = 4;

    // 33-bit arithmetic so a window touching the top of the map cannot wrap.
    function automatic logic in_window(input logic [31:0] adr,
                                       input logic [31:0] base,
                                       input logic [32:0] span);
        logic [32:0] lo;
        logic [32:0] hi;
        lo = {1'b0, base};
        hi = lo + span;
        return ({1'b0, adr} >= lo) && ({1'b0, adr} < hi);
    endfunction

endpackage

// File: rtl/bram_sp.sv
// Single-port DEPTH x 32 RAM with per-byte write enables and a registered read.
module bram_sp #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rd,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   din,
    output logic [31:0]   dout
);

    logic [31:0] mem [DEPTH];

    // Byte-masked write and registered read; the array is never reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                mem[addr][8*b +: 8] <= din[8*b +: 8];
            end
        end
        if (rd) begin
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/wb_ram_responder.sv
// Wishbone slave fronting a byte-writable RAM; every access is acknowledged a
// fixed number of cycles after it is accepted, followed by one dead cycle.
module wb_ram_responder
    import wb_pkg::*;
#(
    parameter int          DELAYS    = 10,
    parameter logic [31:0] BASE_ADDR = WB_BASE_ADDR,
    parameter int          DEPTH     = 1024
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o
);

    localparam int               AW   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(DELAYS - 1);
    localparam logic [32:0]      SPAN = 33'(4 * DEPTH);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic [3:0]       sel_q;
    logic [31:0]      dat_q;
    logic [31:0]      adr_q;
    logic             ack;

    logic             req;
    logic             in_range;
    logic [31:0]      offset;
    logic [AW-1:0]    idx;
    logic             rd_en;
    logic [3:0]       wr_be;
    logic [31:0]      rdata;

    assign req      = wbs_stb_i & wbs_cyc_i;
    assign in_range = in_window(adr_q, BASE_ADDR, SPAN);
    assign offset   = adr_q - BASE_ADDR;
    assign idx      = AW'(offset >> 2);

    // The read is launched in the final wait cycle so its data lands in ACK.
    assign rd_en = (state == ST_WAIT) && (cnt == 4'd0) && req && !we_q && in_range;
    assign wr_be = ((state == ST_ACK) && we_q && in_range) ? sel_q : 4'b0000;

    assign wbs_ack_o = ack;
    assign wbs_dat_o = (ack && !we_q && in_range) ? rdata : 32'd0;

    // Transfer FSM: capture, count down, single-cycle ack, dead cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            we_q  <= 1'b0;
            sel_q <= 4'b0000;
            dat_q <= 32'd0;
            adr_q <= 32'd0;
            ack   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ack <= 1'b0;
                    if (req) begin
                        state <= ST_WAIT;
                        cnt   <= LOAD;
                        we_q  <= wbs_we_i;
                        sel_q <= wbs_sel_i;
                        dat_q <= wbs_dat_i;
                        adr_q <= wbs_adr_i;
                    end
                end
                ST_WAIT: begin
                    if (!req) begin
                        state <= ST_IDLE;
                        ack   <= 1'b0;
                    end else if (cnt == 4'd0) begin
                        state <= ST_ACK;
                        ack   <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_ACK: begin
                    state <= ST_DONE;
                    ack   <= 1'b0;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    ack   <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    ack   <= 1'b0;
                end
            endcase
        end
    end

    bram_sp #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk  (wb_clk_i),
        .rd   (rd_en),
        .be   (wr_be),
        .addr (idx),
        .din  (dat_q),
        .dout (rdata)
    );

endmodule
